// File: rtl/alu_arbiter_pkg.sv
// Shared definitions for the two-port ALU arbiter: opcode encodings, FSM states
// and the round-robin pick helper.
package alu_arbiter_pkg;

  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_SUB = 3'b110;
  localparam logic [2:0] OP_AND = 3'b000;
  localparam logic [2:0] OP_OR  = 3'b001;
  localparam logic [2:0] OP_SLT = 3'b111;

  localparam int NUM_PORTS = 2;
  localparam int DATA_W    = 32;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_HOLD = 2'd2
  } state_t;

  // Returns the granted port index. Both valid -> the port not served last;
  // otherwise the single valid port (port 0 when nobody asks; callers mask that).
  function automatic logic rr_pick(input logic [NUM_PORTS-1:0] valid, input logic last);
    if (valid == 2'b11) begin
      return ~last;
    end
    return valid[1];
  endfunction

endpackage

// File: rtl/alu_arbiter_alu.sv
// Combinational 32-bit ALU shared by the arbiter; unknown opcodes yield zero.
module alu_arbiter_alu
  import alu_arbiter_pkg::*;
(
  input  logic [2:0]        op,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [DATA_W-1:0] y
);

  always_comb begin
    y = '0;
    case (op)
      OP_ADD: y = a + b;
      OP_SUB: y = a - b;
      OP_AND: y = a & b;
      OP_OR:  y = a | b;
      // slt is an unsigned compare
      OP_SLT: y = (a < b) ? 32'd1 : 32'd0;
      default: y = '0;
    endcase
  end

endmodule

// File: rtl/alu_arbiter.sv
// Two requesters share one ALU through an IDLE/EXEC/HOLD FSM with round-robin grant.
// Optional res_zero output is enabled by defining ALU_ARB_ZERO_FLAG_EN.
module alu_arbiter
  import alu_arbiter_pkg::*;
#(
  parameter int TAG_W = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              r0_valid,
  input  logic              r1_valid,
  output logic              r0_ready,
  output logic              r1_ready,
  input  logic [2:0]        r0_op,
  input  logic [2:0]        r1_op,
  input  logic [31:0]       r0_a,
  input  logic [31:0]       r0_b,
  input  logic [31:0]       r1_a,
  input  logic [31:0]       r1_b,
  input  logic [TAG_W-1:0]  r0_tag,
  input  logic [TAG_W-1:0]  r1_tag,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [31:0]       res_data,
  output logic              res_src,
  output logic [TAG_W-1:0]  res_tag
`ifdef ALU_ARB_ZERO_FLAG_EN
  ,output logic             res_zero
`endif
);

  state_t state_reg, state_next;

  logic                 last_reg;
  logic [2:0]           op_reg;
  logic [DATA_W-1:0]    a_reg;
  logic [DATA_W-1:0]    b_reg;
  logic [TAG_W-1:0]     tag_reg;
  logic                 src_reg;

  logic [DATA_W-1:0]    res_data_reg;
  logic                 res_src_reg;
  logic [TAG_W-1:0]     res_tag_reg;

  logic [NUM_PORTS-1:0] req_valid;
  logic [NUM_PORTS-1:0] req_ready;
  logic                 grant;
  logic                 grant_en;
  logic                 transfer;

  logic [2:0]           sel_op;
  logic [DATA_W-1:0]    sel_a;
  logic [DATA_W-1:0]    sel_b;
  logic [TAG_W-1:0]     sel_tag;
  logic [DATA_W-1:0]    alu_y;

  assign req_valid = {r1_valid, r0_valid};
  assign grant_en  = |req_valid;
  assign grant     = rr_pick(req_valid, last_reg);

  genvar gi;
  generate
    for (gi = 0; gi < NUM_PORTS; gi++) begin : g_ready
      assign req_ready[gi] = (state_reg == ST_IDLE) && grant_en && (grant == 1'(gi));
    end
  endgenerate

  assign r0_ready = req_ready[0];
  assign r1_ready = req_ready[1];
  assign transfer = |(req_valid & req_ready);

  assign sel_op  = grant ? r1_op  : r0_op;
  assign sel_a   = grant ? r1_a   : r0_a;
  assign sel_b   = grant ? r1_b   : r0_b;
  assign sel_tag = grant ? r1_tag : r0_tag;

  alu_arbiter_alu u_alu (
    .op (op_reg),
    .a  (a_reg),
    .b  (b_reg),
    .y  (alu_y)
  );

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE: if (transfer) state_next = ST_EXEC;
      ST_EXEC: state_next = ST_HOLD;
      ST_HOLD: if (res_ready) state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg <= ST_IDLE;
      last_reg  <= 1'b1;
      op_reg    <= '0;
      a_reg     <= '0;
      b_reg     <= '0;
      tag_reg   <= '0;
      src_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      if (transfer) begin
        last_reg <= grant;
        op_reg   <= sel_op;
        a_reg    <= sel_a;
        b_reg    <= sel_b;
        tag_reg  <= sel_tag;
        src_reg  <= grant;
      end
    end
  end

  // Result fields only change on the EXEC cycle, so they hold through any HOLD stall.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      res_data_reg <= '0;
      res_src_reg  <= 1'b0;
      res_tag_reg  <= '0;
    end else if (state_reg == ST_EXEC) begin
      res_data_reg <= alu_y;
      res_src_reg  <= src_reg;
      res_tag_reg  <= tag_reg;
    end
  end

`ifdef ALU_ARB_ZERO_FLAG_EN
  logic res_zero_reg;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      res_zero_reg <= 1'b0;
    end else if (state_reg == ST_EXEC) begin
      res_zero_reg <= (alu_y == '0);
    end
  end

  assign res_zero = res_zero_reg;
`endif

  assign res_valid = (state_reg == ST_HOLD);
  assign res_data  = res_data_reg;
  assign res_src   = res_src_reg;
  assign res_tag   = res_tag_reg;

  a_ready_onehot: assert property (@(posedge clk) disable iff (reset) !(r0_ready && r1_ready));

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed table-driven bench for alu_arbiter plus hand sequences for HOLD stall and reset abort.
module tb_alu_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        r0_valid, r1_valid;
  logic        r0_ready, r1_ready;
  logic [2:0]  r0_op, r1_op;
  logic [31:0] r0_a, r0_b, r1_a, r1_b;
  logic [3:0]  r0_tag, r1_tag;
  logic        res_valid;
  logic        res_ready;
  logic [31:0] res_data;
  logic        res_src;
  logic [3:0]  res_tag;
`ifdef ALU_ARB_ZERO_FLAG_EN
  logic        res_zero;
`endif

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  alu_arbiter #(.TAG_W(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .r0_valid  (r0_valid),
    .r1_valid  (r1_valid),
    .r0_ready  (r0_ready),
    .r1_ready  (r1_ready),
    .r0_op     (r0_op),
    .r1_op     (r1_op),
    .r0_a      (r0_a),
    .r0_b      (r0_b),
    .r1_a      (r1_a),
    .r1_b      (r1_b),
    .r0_tag    (r0_tag),
    .r1_tag    (r1_tag),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_data  (res_data),
    .res_src   (res_src),
    .res_tag   (res_tag)
`ifdef ALU_ARB_ZERO_FLAG_EN
    ,.res_zero (res_zero)
`endif
  );

  typedef struct {
    logic [1:0]  valid;   // {r1, r0}
    logic [2:0]  op0;
    logic [31:0] a0;
    logic [31:0] b0;
    logic [3:0]  tag0;
    logic [2:0]  op1;
    logic [31:0] a1;
    logic [31:0] b1;
    logic [3:0]  tag1;
    logic        exp_src;
    logic [31:0] exp_data;
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    r0_valid = 1'b0; r1_valid = 1'b0;
    r0_op = 3'b000; r1_op = 3'b000;
    r0_a = '0; r0_b = '0; r1_a = '0; r1_b = '0;
    r0_tag = '0; r1_tag = '0;
  endtask

  initial begin
    // Round-robin pointer starts at 1 after reset and is tracked in the comments.
    vecs[0] = '{2'b01, 3'b010, 32'd5, 32'd7, 4'd3, 3'b000, 32'd0, 32'd0, 4'd0, 1'b0, 32'd12};
    vecs[1] = '{2'b10, 3'b000, 32'd0, 32'd0, 4'd0, 3'b110, 32'd0, 32'd1, 4'd6, 1'b1, 32'hFFFFFFFF};
    vecs[2] = '{2'b10, 3'b000, 32'd0, 32'd0, 4'd0, 3'b111, 32'd2, 32'hFFFFFFFF, 4'd7, 1'b1, 32'd1};
    // last=1 -> port 0 wins the tie, then alternation
    vecs[3] = '{2'b11, 3'b000, 32'hFF00FF00, 32'h0F0F0F0F, 4'd1, 3'b001, 32'h1, 32'h2, 4'd2, 1'b0, 32'h0F000F00};
    vecs[4] = '{2'b11, 3'b010, 32'd1, 32'd1, 4'd4, 3'b001, 32'h1200, 32'h0034, 4'd8, 1'b1, 32'h1234};
    vecs[5] = '{2'b11, 3'b111, 32'd7, 32'd3, 4'd9, 3'b010, 32'd9, 32'd9, 4'd10, 1'b0, 32'd0};
    vecs[6] = '{2'b11, 3'b010, 32'd4, 32'd4, 4'd11, 3'b110, 32'd3, 32'd5, 4'd12, 1'b1, 32'hFFFFFFFE};
    vecs[7] = '{2'b01, 3'b010, 32'hFFFFFFFF, 32'd2, 4'd13, 3'b000, 32'd0, 32'd0, 4'd0, 1'b0, 32'd1};
    vecs[8] = '{2'b01, 3'b011, 32'd5, 32'd5, 4'd14, 3'b000, 32'd0, 32'd0, 4'd0, 1'b0, 32'd0};
    vecs[9] = '{2'b10, 3'b000, 32'd0, 32'd0, 4'd0, 3'b100, 32'hAAAA, 32'h5555, 4'd15, 1'b1, 32'd0};
  end

  initial begin
    logic [3:0] exp_tag;

    idle_inputs();
    res_ready = 1'b1;
    reset = 1'b1;
    repeat (2) tick();

    check("rst_res_valid", {31'd0, res_valid}, 32'd0);
    check("rst_res_data", res_data, 32'd0);
    check("rst_res_src", {31'd0, res_src}, 32'd0);
    check("rst_res_tag", {28'd0, res_tag}, 32'd0);
    check("rst_readies", {30'd0, r1_ready, r0_ready}, 32'd0);
    reset = 1'b0;
    tick();
    check("idle_no_req_readies", {30'd0, r1_ready, r0_ready}, 32'd0);

    for (int i = 0; i < 10; i++) begin
      r0_valid = vecs[i].valid[0]; r1_valid = vecs[i].valid[1];
      r0_op = vecs[i].op0; r0_a = vecs[i].a0; r0_b = vecs[i].b0; r0_tag = vecs[i].tag0;
      r1_op = vecs[i].op1; r1_a = vecs[i].a1; r1_b = vecs[i].b1; r1_tag = vecs[i].tag1;
      exp_tag = vecs[i].exp_src ? vecs[i].tag1 : vecs[i].tag0;
      #1;
      check($sformatf("v%0d_grant", i), {30'd0, r1_ready, r0_ready},
            vecs[i].exp_src ? 32'd2 : 32'd1);
      tick();  // transfer edge N
      idle_inputs();
      check($sformatf("v%0d_exec_valid", i), {31'd0, res_valid}, 32'd0);
      check($sformatf("v%0d_exec_readies", i), {30'd0, r1_ready, r0_ready}, 32'd0);
      tick();  // result visible at edge N+2
      check($sformatf("v%0d_valid", i), {31'd0, res_valid}, 32'd1);
      check($sformatf("v%0d_data", i), res_data, vecs[i].exp_data);
      check($sformatf("v%0d_src", i), {31'd0, res_src}, {31'd0, vecs[i].exp_src});
      check($sformatf("v%0d_tag", i), {28'd0, res_tag}, {28'd0, exp_tag});
`ifdef ALU_ARB_ZERO_FLAG_EN
      check($sformatf("v%0d_zero", i), {31'd0, res_zero}, {31'd0, vecs[i].exp_data == 32'd0});
`endif
      $display("txn %0d: src=%0d tag=%0d data=%h", i, res_src, res_tag, res_data);
      tick();  // handshake
      check($sformatf("v%0d_idle", i), {31'd0, res_valid}, 32'd0);
    end

    // HOLD stall: result stays put, requests ignored, one handshake, no ghost transaction.
    res_ready = 1'b0;
    r0_valid = 1'b1; r0_op = 3'b010; r0_a = 32'd10; r0_b = 32'd20; r0_tag = 4'd5;
    tick();
    idle_inputs();
    tick();
    r0_valid = 1'b1; r1_valid = 1'b1;
    r0_op = 3'b001; r0_a = 32'hDEAD; r1_op = 3'b010; r1_a = 32'hBEEF; r1_tag = 4'd9;
    for (int k = 0; k < 5; k++) begin
      check($sformatf("hold%0d_valid", k), {31'd0, res_valid}, 32'd1);
      check($sformatf("hold%0d_data", k), res_data, 32'd30);
      check($sformatf("hold%0d_tag_src", k), {27'd0, res_tag, res_src}, {27'd0, 4'd5, 1'b0});
      check($sformatf("hold%0d_readies", k), {30'd0, r1_ready, r0_ready}, 32'd0);
      tick();
    end
    $display("txn stall: src=%0d tag=%0d data=%h", res_src, res_tag, res_data);
    idle_inputs();
    res_ready = 1'b1;
    tick();
    check("stall_release_valid", {31'd0, res_valid}, 32'd0);
    tick();
    tick();
    check("stall_no_ghost", {31'd0, res_valid}, 32'd0);

    // Reset during EXEC: port 0 served last before reset, so a tie afterwards proves the pointer reset.
    r0_valid = 1'b1; r0_op = 3'b010; r0_a = 32'd1; r0_b = 32'd2; r0_tag = 4'd6;
    tick();
    idle_inputs();
    reset = 1'b1;
    #2;
    check("abort_valid", {31'd0, res_valid}, 32'd0);
    check("abort_data", res_data, 32'd0);
    reset = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      check($sformatf("abort_quiet%0d", k), {31'd0, res_valid}, 32'd0);
    end
    r0_valid = 1'b1; r0_op = 3'b011; r0_a = 32'd5; r0_b = 32'd9; r0_tag = 4'd2;
    r1_valid = 1'b1; r1_op = 3'b010; r1_a = 32'd5; r1_b = 32'd9; r1_tag = 4'd4;
    #1;
    check("post_reset_tie", {30'd0, r1_ready, r0_ready}, 32'd1);
    tick();
    idle_inputs();
    tick();
    check("badop_valid", {31'd0, res_valid}, 32'd1);
    check("badop_data", res_data, 32'd0);
    check("badop_tag_src", {27'd0, res_tag, res_src}, {27'd0, 4'd2, 1'b0});
`ifdef ALU_ARB_ZERO_FLAG_EN
    check("badop_zero", {31'd0, res_zero}, 32'd1);
`endif
    $display("txn badop: src=%0d tag=%0d data=%h", res_src, res_tag, res_data);
    tick();
    check("final_idle", {31'd0, res_valid}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 SHALL have parameter TAG_W, default 4, width of the requester transaction tag.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have ports r0_valid / r1_valid  input  1  request present on port 0 / 1.
REQ-005 SHALL have ports r0_ready / r1_ready  output  1  request accepted this cycle.
REQ-006 SHALL have ports r0_op / r1_op  input  3  ALU opcode (010 add, 110 sub, 000 and, 001 or, 111 slt).
REQ-007 SHALL have ports r0_a, r0_b / r1_a, r1_b  input  32  operands.
REQ-008 SHALL have ports r0_tag / r1_tag  input  TAG_W  requester tag, returned with result.
REQ-009 SHALL have port res_valid  output  1  result available.
REQ-010 SHALL have port res_ready  input  1  consumer accepts result.
REQ-011 SHALL have port res_data  output  32  ALU result.
REQ-012 SHALL have ports res_src  output  1  (0 = port 0, 1 = port 1) and res_tag  output  TAG_W.

Function
REQ-013 SHALL share one 32-bit ALU between two requesters via FSM states IDLE, EXEC, HOLD.
REQ-014 In IDLE, SHALL grant exactly one valid requester; r<i>_ready = (state==IDLE) && grant==i; transfer occurs when valid && ready.
REQ-015 Arbitration SHALL be round-robin: single requester always wins; if both valid, winner is the port not served last; last-served pointer updates only on transfer.
REQ-016 On transfer, SHALL register op, a, b, tag, src and move IDLE->EXEC; no transfer keeps IDLE.
REQ-017 In EXEC, SHALL drive the ALU from registered operands, capture result into res_data, and move EXEC->HOLD unconditionally.
REQ-018 In HOLD, res_valid=1; res_data, res_src and res_tag SHALL stay stable until res_valid && res_ready, then HOLD->IDLE.
REQ-019 Latency SHALL be: transfer at edge N, res_valid high from edge N+2; max throughput one op per 3 cycles with res_ready tied high.
REQ-020 Opcodes outside the five listed SHALL produce res_data = 0 and complete normally.
REQ-021 slt SHALL be unsigned compare yielding 32'd1 or 32'd0; add/sub SHALL wrap modulo 2^32 with carry discarded.
REQ-022 r0_ready and r1_ready SHALL never both be 1; both SHALL be 0 outside IDLE.
REQ-023 Request inputs SHALL be ignored outside IDLE; a requester dropping valid before transfer SHALL lose its grant without side effect.

Reset
REQ-024 Reset SHALL force state=IDLE, res_valid=0, res_data=0, res_src=0, res_tag=0, last-served pointer=1 (port 0 wins first tie).
REQ-025 Reset asserted in EXEC or HOLD SHALL abort the transaction; no result SHALL appear after reset release.

Configuration
REQ-026 With ALU_ARB_ZERO_FLAG_EN defined, SHALL add output res_zero (1 bit) = (res_data == 0), registered with res_data, reset 0.
REQ-027 Without ALU_ARB_ZERO_FLAG_EN, res_zero port and logic SHALL be absent; other behaviour identical.

Structure
REQ-028 Shared package SHALL hold opcode constants (OP_ADD=3'b010, OP_SUB=3'b110, OP_AND=3'b000, OP_OR=3'b001, OP_SLT=3'b111) and FSM state encoding.
REQ-029 SHALL instantiate the existing combinational ALU as its only sub-module; arbitration and FSM SHALL be in alu_arbiter.

Verification
REQ-030 r0 only: op=010, a=5, b=7, tag=3 -> res_valid at N+2, res_data=12, res_src=0, res_tag=3.
REQ-031 Both valid every IDLE cycle, res_ready=1 -> grants alternate 0,1,0,1 starting with port 0; no requester starved.
REQ-032 r1: op=110, a=0, b=1 -> res_data=32'hFFFFFFFF; op=111, a=2, b=32'hFFFFFFFF -> res_data=1.
REQ-033 res_ready held 0 for 5 cycles in HOLD -> res_data/tag/src stable, both readies 0, then single handshake and return to IDLE.
REQ-034 Reset pulse during EXEC -> res_valid 0 immediately, no result after release, next tie grants port 0; op=011 -> res_data=0 (res_zero=1 when ALU_ARB_ZERO_FLAG_EN).
